// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pkg
// Purpose  : Shared widths, screen defaults, slot-state type and the
//            vertical-velocity saturation helper for the bullet pool.
// Revision : 1.0  initial release
// ============================================================================
package bullet_pkg;

   // Fixed-point scale and port widths
   localparam int C_FRAC     = 4;
   localparam int C_X_W      = 10;
   localparam int C_Y_W      = 9;
   localparam int C_VX_W     = 8;
   localparam int C_VY_W     = 13;
   localparam int C_DROP_W   = 8;

   // Default visible screen
   localparam int C_SCREEN_W = 640;
   localparam int C_SCREEN_H = 480;

   // Position width: pixel bits + fraction + one guard/sign bit
   localparam int C_PX_W     = C_X_W + C_FRAC + 1;
   localparam int C_PY_W     = C_Y_W + C_FRAC + 1;

   // Signed 13-bit limits for vy
   localparam int C_VY_MAX   = (1 << (C_VY_W - 1)) - 1;
   localparam int C_VY_MIN   = -(1 << (C_VY_W - 1));

   // Register image of one slot in the default fixed-point configuration
   typedef struct packed {
      logic                     active;
      logic signed [C_PX_W-1:0] px;
      logic signed [C_PY_W-1:0] py;
      logic signed [C_VX_W-1:0] vx;
      logic signed [C_VY_W-1:0] vy;
   } slot_state_t;

   // Clamp a wide vy result back into the 13-bit signed range
   function automatic logic signed [C_VY_W-1:0] sat_vy(input int v);
      if (v > C_VY_MAX) begin
         return C_VY_W'(C_VY_MAX);
      end
      if (v < C_VY_MIN) begin
         return C_VY_W'(C_VY_MIN);
      end
      return C_VY_W'(v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
// Module   : bullet_slot
// Purpose  : One bullet slot: launch load, fixed-point integration, gravity
//            on vy with saturation, and off-screen retirement.
// Revision : 1.0  initial release
// ============================================================================
module bullet_slot
   import bullet_pkg::*;
#(
   parameter int FRAC     = C_FRAC,
   parameter int SCREEN_W = C_SCREEN_W,
   parameter int SCREEN_H = C_SCREEN_H,
   parameter int GRAV_16X = 0
)(
   input  logic              clk_100Hz,
   input  logic              rst,
   input  logic              load,
   input  logic [C_X_W-1:0]  x_din,
   input  logic [C_Y_W-1:0]  y_din,
   input  logic [C_VX_W-1:0] vx_din_16x,
   input  logic [C_VY_W-1:0] vy_din_16x,
   output logic              active,
   output logic [C_X_W-1:0]  x_pix,
   output logic [C_Y_W-1:0]  y_pix
);

   localparam int C_PXW   = C_X_W + FRAC + 1;
   localparam int C_PYW   = C_Y_W + FRAC + 1;
   // First fixed-point position past the right / bottom screen edge
   localparam int C_X_LIM = SCREEN_W << FRAC;
   localparam int C_Y_LIM = SCREEN_H << FRAC;

   logic signed [C_PXW-1:0]  r_px;
   logic signed [C_PXW-1:0]  w_px_next;
   logic signed [C_PYW-1:0]  r_py;
   logic signed [C_PYW-1:0]  w_py_next;
   logic signed [C_VX_W-1:0] r_vx;
   logic signed [C_VY_W-1:0] r_vy;
   logic signed [C_VY_W-1:0] w_vy_next;
   logic                     r_active;
   logic                     w_out;

   // Next position uses the pre-gravity vy; exit test is on the new position.
   // Any wrap of the guard bit lands negative or past the limit, so it still retires.
   always_comb begin
      w_px_next = r_px + {{(C_PXW - C_VX_W){r_vx[C_VX_W-1]}}, r_vx};
      w_py_next = r_py + {{(C_PYW - C_VY_W){r_vy[C_VY_W-1]}}, r_vy};
      w_vy_next = sat_vy(int'(r_vy) + GRAV_16X);
      w_out     = (w_px_next < 0) || (int'(w_px_next) >= C_X_LIM) ||
                  (w_py_next < 0) || (int'(w_py_next) >= C_Y_LIM);
   end

   // Load on launch, integrate while active, hold everything while idle
   always_ff @(posedge clk_100Hz or posedge rst) begin
      if (rst) begin
         r_px     <= '0;
         r_py     <= '0;
         r_vx     <= '0;
         r_vy     <= '0;
         r_active <= 1'b0;
      end else if (load) begin
         r_px     <= {1'b0, x_din, {FRAC{1'b0}}};
         r_py     <= {1'b0, y_din, {FRAC{1'b0}}};
         r_vx     <= vx_din_16x;
         r_vy     <= vy_din_16x;
         r_active <= 1'b1;
      end else if (r_active) begin
         r_px     <= w_px_next;
         r_py     <= w_py_next;
         r_vy     <= w_vy_next;
         r_active <= !w_out;
      end
   end

   assign active = r_active;
   assign x_pix  = r_px[FRAC +: C_X_W];
   assign y_pix  = r_py[FRAC +: C_Y_W];

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool
// Purpose  : Pool of N_SLOTS bullets: lowest-free-slot allocation, fire
//            acknowledge, saturating drop counter and renderer read port.
// Revision : 1.0  initial release
// ============================================================================
module bullet_pool
   import bullet_pkg::*;
#(
   parameter int N_SLOTS  = 8,
   parameter int FRAC     = C_FRAC,
   parameter int SCREEN_W = C_SCREEN_W,
   parameter int SCREEN_H = C_SCREEN_H,
   parameter int GRAV_16X = 0,
   localparam int IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
)(
   input  logic                clk_100Hz,
   input  logic                rst,
   input  logic                fire,
   input  logic [C_X_W-1:0]    x_din,
   input  logic [C_Y_W-1:0]    y_din,
   input  logic [C_VX_W-1:0]   vx_din_16x,
   input  logic [C_VY_W-1:0]   vy_din_16x,
   output logic                fire_ack,
   output logic                full,
   output logic [N_SLOTS-1:0]  active_mask,
   input  logic [IDX_W-1:0]    rd_idx,
   output logic [C_X_W-1:0]    rd_x,
   output logic [C_Y_W-1:0]    rd_y,
   output logic                rd_active,
   output logic [C_DROP_W-1:0] drop_cnt
);

   logic [N_SLOTS-1:0]  w_free;
   logic [N_SLOTS-1:0]  w_grant;
   logic [N_SLOTS-1:0]  w_load;
   logic [C_X_W-1:0]    w_x_pix [N_SLOTS];
   logic [C_Y_W-1:0]    w_y_pix [N_SLOTS];
   logic                w_full;
   logic                w_accept;
   logic                w_drop;
   logic                r_fire_ack;
   logic [C_DROP_W-1:0] r_drop_cnt;

   // Allocation sees the mask as it stood before this edge, so a slot that
   // retires on this edge only becomes grantable on the next one.
   assign w_free   = ~active_mask;
   assign w_grant  = w_free & (~w_free + N_SLOTS'(1));   // isolate lowest free bit
   assign w_full   = &active_mask;
   assign w_accept = fire & ~w_full;
   assign w_drop   = fire & w_full;
   assign w_load   = w_grant & {N_SLOTS{w_accept}};

   generate
      for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot
         bullet_slot #(
            .FRAC     (FRAC),
            .SCREEN_W (SCREEN_W),
            .SCREEN_H (SCREEN_H),
            .GRAV_16X (GRAV_16X)
         ) u_slot (
            .clk_100Hz  (clk_100Hz),
            .rst        (rst),
            .load       (w_load[gi]),
            .x_din      (x_din),
            .y_din      (y_din),
            .vx_din_16x (vx_din_16x),
            .vy_din_16x (vy_din_16x),
            .active     (active_mask[gi]),
            .x_pix      (w_x_pix[gi]),
            .y_pix      (w_y_pix[gi])
         );
      end
   endgenerate

   // Acknowledge accepted fires one cycle later; count rejected fires up to 255
   always_ff @(posedge clk_100Hz or posedge rst) begin
      if (rst) begin
         r_fire_ack <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_fire_ack <= w_accept;
         if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + C_DROP_W'(1);
         end
      end
   end

   // Renderer read: zeros for an idle slot or an index past the pool
   always_comb begin
      rd_active = 1'b0;
      rd_x      = '0;
      rd_y      = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if ((int'(rd_idx) == i) && active_mask[i]) begin
            rd_active = 1'b1;
            rd_x      = w_x_pix[i];
            rd_y      = w_y_pix[i];
         end
      end
   end

   assign full     = w_full;
   assign fire_ack = r_fire_ack;
   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_pool
// Purpose  : Self-checking bench for bullet_pool: a straight-line pool and a
//            gravity pool share stimulus; an integer reference model predicts
//            every output each cycle, directed scenarios pin known values.
// Revision : 1.0  initial release
// ============================================================================
module tb_bullet_pool;

   localparam int N  = 8;
   localparam int NI = 2;            // instance 0: no gravity, instance 1: gravity 8

   logic        clk_100Hz = 1'b0;
   logic        rst;
   logic        fire;
   logic [9:0]  x_din;
   logic [8:0]  y_din;
   logic [7:0]  vx_din;
   logic [12:0] vy_din;
   logic [2:0]  rd_idx;

   logic        ack_o  [NI];
   logic        full_o [NI];
   logic [7:0]  mask_o [NI];
   logic [9:0]  rdx_o  [NI];
   logic [8:0]  rdy_o  [NI];
   logic        rda_o  [NI];
   logic [7:0]  drop_o [NI];

   int total = 0;
   int bad   = 0;
   bit running = 1'b0;

   always #5 clk_100Hz = ~clk_100Hz;

   bullet_pool #(.N_SLOTS(N), .GRAV_16X(0)) dut (
      .clk_100Hz(clk_100Hz), .rst(rst), .fire(fire),
      .x_din(x_din), .y_din(y_din), .vx_din_16x(vx_din), .vy_din_16x(vy_din),
      .fire_ack(ack_o[0]), .full(full_o[0]), .active_mask(mask_o[0]),
      .rd_idx(rd_idx), .rd_x(rdx_o[0]), .rd_y(rdy_o[0]), .rd_active(rda_o[0]),
      .drop_cnt(drop_o[0])
   );

   bullet_pool #(.N_SLOTS(N), .GRAV_16X(8)) dut_g (
      .clk_100Hz(clk_100Hz), .rst(rst), .fire(fire),
      .x_din(x_din), .y_din(y_din), .vx_din_16x(vx_din), .vy_din_16x(vy_din),
      .fire_ack(ack_o[1]), .full(full_o[1]), .active_mask(mask_o[1]),
      .rd_idx(rd_idx), .rd_x(rdx_o[1]), .rd_y(rdy_o[1]), .rd_active(rda_o[1]),
      .drop_cnt(drop_o[1])
   );

   // ---------------- reference model (ideal integer arithmetic, 1/16 px) -----
   int m_px  [NI][N];
   int m_py  [NI][N];
   int m_vx  [NI][N];
   int m_vy  [NI][N];
   bit m_act [NI][N];
   bit m_ack [NI];
   int m_drop[NI];

   function automatic int grav_of(input int g);
      return (g == 1) ? 8 : 0;
   endfunction

   function automatic int clamp_vy(input int v);
      if (v > 4095)  return 4095;
      if (v < -4096) return -4096;
      return v;
   endfunction

   task automatic model_clear();
      for (int g = 0; g < NI; g++) begin
         m_ack[g]  = 1'b0;
         m_drop[g] = 0;
         for (int i = 0; i < N; i++) begin
            m_act[g][i] = 1'b0;
            m_px[g][i] = 0; m_py[g][i] = 0; m_vx[g][i] = 0; m_vy[g][i] = 0;
         end
      end
   endtask

   task automatic model_edge();
      for (int g = 0; g < NI; g++) begin
         int slot;
         slot = -1;
         for (int i = N - 1; i >= 0; i--) begin
            if (!m_act[g][i]) slot = i;
         end
         for (int i = 0; i < N; i++) begin
            if (m_act[g][i]) begin
               m_px[g][i] = m_px[g][i] + m_vx[g][i];
               m_py[g][i] = m_py[g][i] + m_vy[g][i];
               m_vy[g][i] = clamp_vy(m_vy[g][i] + grav_of(g));
               if (m_px[g][i] < 0 || m_px[g][i] >= 640 * 16 ||
                   m_py[g][i] < 0 || m_py[g][i] >= 480 * 16)
                  m_act[g][i] = 1'b0;
            end
         end
         m_ack[g] = 1'b0;
         if (fire) begin
            if (slot >= 0) begin
               m_act[g][slot] = 1'b1;
               m_px[g][slot]  = int'(x_din) * 16;
               m_py[g][slot]  = int'(y_din) * 16;
               m_vx[g][slot]  = int'($signed(vx_din));
               m_vy[g][slot]  = int'($signed(vy_din));
               m_ack[g]       = 1'b1;
            end else if (m_drop[g] < 255) begin
               m_drop[g] = m_drop[g] + 1;
            end
         end
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk_100Hz or posedge rst);
         if (rst) model_clear();
         else     model_edge();
      end
   end

   // ---------------- checking ------------------------------------------------
   task automatic check(input string name, input logic [31:0] got, input int exp);
      total = total + 1;
      if (got !== 32'(exp)) begin
         bad = bad + 1;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int g = 0; g < NI; g++) begin
         int emask;
         int ea, ex, ey;
         emask = 0;
         for (int i = 0; i < N; i++) if (m_act[g][i]) emask = emask | (1 << i);
         ea = m_act[g][rd_idx] ? 1 : 0;
         ex = ea ? ((m_px[g][rd_idx] >>> 4) & 1023) : 0;
         ey = ea ? ((m_py[g][rd_idx] >>> 4) & 511)  : 0;
         check($sformatf("model_ack[%0d]", g),  32'(ack_o[g]),  m_ack[g] ? 1 : 0);
         check($sformatf("model_full[%0d]", g), 32'(full_o[g]), (emask == 255) ? 1 : 0);
         check($sformatf("model_mask[%0d]", g), 32'(mask_o[g]), emask);
         check($sformatf("model_drop[%0d]", g), 32'(drop_o[g]), m_drop[g]);
         check($sformatf("model_rda[%0d]", g),  32'(rda_o[g]),  ea);
         check($sformatf("model_rdx[%0d]", g),  32'(rdx_o[g]),  ex);
         check($sformatf("model_rdy[%0d]", g),  32'(rdy_o[g]),  ey);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_100Hz);
         #2;
         if (running) compare_all();
      end
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic tick();
      @(posedge clk_100Hz);
      #3;
   endtask

   task automatic set_shot(input int x, input int y, input int vx, input int vy);
      x_din  = 10'(x);
      y_din  = 9'(y);
      vx_din = 8'(vx);
      vy_din = 13'(vy);
   endtask

   task automatic do_reset();
      fire = 1'b0;
      rst  = 1'b1;
      tick();
      tick();
      rst  = 1'b0;
   endtask

   int gy_exp [5] = '{0, 0, 0, 1, 3};

   // ---------------- main sequence -------------------------------------------
   initial begin
      rst = 1'b1;
      fire = 1'b0;
      rd_idx = 3'd0;
      set_shot(0, 0, 0, 0);
      running = 1'b1;
      tick();

      // Reset state
      check("rst_mask", 32'(mask_o[0]), 0);
      check("rst_full", 32'(full_o[0]), 0);
      check("rst_ack",  32'(ack_o[0]),  0);
      check("rst_drop", 32'(drop_o[0]), 0);
      check("rst_rda",  32'(rda_o[0]),  0);

      // Fire while in reset is ignored and not counted
      fire = 1'b1;
      set_shot(100, 100, 0, 0);
      tick();
      check("rst_fire_mask", 32'(mask_o[0]), 0);
      check("rst_fire_drop", 32'(drop_o[0]), 0);
      fire = 1'b0;
      rst  = 1'b0;

      // Straight-line flight: slot 0, then three edges of motion
      set_shot(100, 50, 16, -32);
      fire = 1'b1;
      tick();
      fire = 1'b0;
      check("launch_ack",  32'(ack_o[0]),  1);
      check("launch_mask", 32'(mask_o[0]), 1);
      rd_idx = 3'd0;
      #1;
      check("launch_x", 32'(rdx_o[0]), 100);
      check("launch_y", 32'(rdy_o[0]), 50);
      repeat (3) tick();
      rd_idx = 3'd0;
      #1;
      check("flight_x",   32'(rdx_o[0]), 103);
      check("flight_y",   32'(rdy_o[0]), 44);
      check("flight_act", 32'(rda_o[0]), 1);
      do_reset();

      // Gravity: y pixel 0,0,0,1,3 on launch edge and following edges
      set_shot(10, 0, 0, 0);
      fire = 1'b1;
      tick();
      fire = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         rd_idx = 3'd0;
         #1;
         check($sformatf("grav_y%0d", k), 32'(rdy_o[1]), gy_exp[k]);
         check($sformatf("grav_act%0d", k), 32'(rda_o[1]), 1);
      end
      do_reset();

      // Fill all slots, then overflow and saturate the drop counter
      set_shot(320, 240, 0, 0);
      fire = 1'b1;
      repeat (8) tick();
      check("fill_mask", 32'(mask_o[0]), 255);
      check("fill_full", 32'(full_o[0]), 1);
      check("fill_drop", 32'(drop_o[0]), 0);
      tick();
      check("ovf_ack",  32'(ack_o[0]),  0);
      check("ovf_drop", 32'(drop_o[0]), 1);
      check("ovf_mask", 32'(mask_o[0]), 255);
      repeat (299) tick();
      fire = 1'b0;
      check("sat_drop", 32'(drop_o[0]), 255);
      do_reset();
      check("drop_cleared", 32'(drop_o[0]), 0);

      // Slot 2 sits at x=639 vx=16 the edge before a fire into a full pool
      fire = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 2)      set_shot(634, 240, 16, 0);
         else if (k == 9) set_shot(5, 5, 0, 0);
         else             set_shot(320, 240, 0, 0);
         tick();
         if (k == 7) check("reuse_full_mask", 32'(mask_o[0]), 255);
         if (k == 8) begin
            check("reuse_drop_ack",  32'(ack_o[0]),  0);
            check("reuse_drop_cnt",  32'(drop_o[0]), 1);
            check("reuse_exit_mask", 32'(mask_o[0]), 8'hFB);
         end
         if (k == 9) begin
            check("reuse_ack",  32'(ack_o[0]),  1);
            check("reuse_mask", 32'(mask_o[0]), 255);
            rd_idx = 3'd2;
            #1;
            check("reuse_x", 32'(rdx_o[0]), 5);
            check("reuse_y", 32'(rdy_o[0]), 5);
         end
      end
      fire = 1'b0;
      do_reset();

      // Off-screen launch lives one cycle; empty slot reads zero
      set_shot(700, 100, 0, 0);
      fire = 1'b1;
      tick();
      fire = 1'b0;
      check("off_mask", 32'(mask_o[0]), 1);
      rd_idx = 3'd0;
      #1;
      check("off_rda", 32'(rda_o[0]), 1);
      check("off_rdx", 32'(rdx_o[0]), 700);
      tick();
      check("off_gone", 32'(mask_o[0]), 0);
      rd_idx = 3'd7;
      #1;
      check("empty_rda", 32'(rda_o[0]), 0);
      check("empty_rdx", 32'(rdx_o[0]), 0);
      check("empty_rdy", 32'(rdy_o[0]), 0);
      do_reset();

      // Reset mid-flight clears immediately; next fire goes to slot 0
      set_shot(200, 200, 1, 1);
      fire = 1'b1;
      repeat (5) tick();
      fire = 1'b0;
      check("flight5_mask", 32'(mask_o[0]), 8'h1F);
      rst = 1'b1;
      #1;
      check("async_rst_mask", 32'(mask_o[0]), 0);
      check("async_rst_full", 32'(full_o[0]), 0);
      tick();
      rst = 1'b0;
      set_shot(50, 60, 0, 0);
      fire = 1'b1;
      tick();
      fire = 1'b0;
      check("post_rst_mask", 32'(mask_o[0]), 1);
      rd_idx = 3'd0;
      #1;
      check("post_rst_x", 32'(rdx_o[0]), 50);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int xv, yv, vxv, vyv;
         fire = ($urandom_range(0, 99) < 55);
         xv = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, 639)) : int'($urandom_range(0, 1023));
         yv = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 511));
         if ($urandom_range(0, 99) < 85) begin
            vxv = int'($urandom_range(0, 16)) - 8;
            vyv = int'($urandom_range(0, 16)) - 8;
         end else begin
            vxv = int'($urandom_range(0, 255)) - 128;
            vyv = int'($urandom_range(0, 8191)) - 4096;
         end
         set_shot(xv, yv, vxv, vyv);
         rd_idx = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 1'b0;
      fire = 1'b0;
      tick();
      running = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter N_SLOTS, default 8, number of concurrent bullet slots (1..32).
REQ-002 Parameter FRAC, default 4, fractional bits of velocity/position (16x scale).
REQ-003 Parameter SCREEN_W, default 640; SCREEN_H, default 480; visible pixel bounds.
REQ-004 Parameter GRAV_16X, default 0, signed vy increment per tick (0 = straight-line mode).
REQ-005 clk_100Hz  in  1  game tick clock; one clock, all state on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 fire  in  1  one-cycle request to launch a bullet.
REQ-008 x_din  in  10  launch x (pixels); y_din  in  9  launch y (pixels).
REQ-009 vx_din_16x  in  8  signed x velocity, 1/16 px per tick; vy_din_16x  in  13  signed y velocity, 1/16 px per tick.
REQ-010 fire_ack  out  1  registered, high one cycle when a fire was accepted.
REQ-011 full  out  1  combinational, high when all slots active.
REQ-012 active_mask  out  N_SLOTS  bit i high when slot i active.
REQ-013 rd_idx  in  $clog2(N_SLOTS)  renderer slot select.
REQ-014 rd_x  out  10, rd_y  out  9, rd_active  out  1  combinational read of slot rd_idx.
REQ-015 drop_cnt  out  8  saturating count of fires rejected because full.

Function
REQ-016 Each slot SHALL hold signed position px, py of width (pixel width + FRAC + 1 guard bit), signed vx (8b), vy (13b), and an active flag.
REQ-017 On a rising edge with fire=1 and full=0, the lowest-index inactive slot SHALL load px=x_din<<FRAC, py=y_din<<FRAC, vx, vy and set active; fire_ack=1 next cycle.
REQ-018 A slot loaded at edge k SHALL NOT move at edge k; first update at edge k+1.
REQ-019 Every edge, each already-active slot SHALL update px+=sext(vx), py+=sext(vy), then vy+=GRAV_16X with vy saturating at 13-bit signed limits.
REQ-020 A slot SHALL clear active at the edge whose updated px>>FRAC is <0 or >SCREEN_W-1, or py>>FRAC is <0 or >SCREEN_H-1.
REQ-021 Allocation SHALL use the active mask before the current edge; a slot freed at edge k is allocatable from edge k+1 only.
REQ-022 fire with full=1 SHALL change no slot, fire_ack=0, drop_cnt+=1 saturating at 255.
REQ-023 Launch coordinates outside screen bounds SHALL be accepted; the slot clears at its first update edge.
REQ-024 rd_x=px>>FRAC, rd_y=py>>FRAC truncated to port width; inactive slot or rd_idx>=N_SLOTS SHALL give rd_active=0, rd_x=0, rd_y=0.
REQ-025 Inactive slots SHALL hold their registers unchanged (no movement, no gravity).

Reset
REQ-026 rst=1 SHALL immediately clear all active flags, px, py, vx, vy, fire_ack, drop_cnt; active_mask=0, full=0.
REQ-027 rst asserted mid-flight SHALL discard all bullets; fire during rst is ignored and not counted.
REQ-028 First fire after rst deassertion SHALL take slot 0.

Structure
REQ-029 Package bullet_pkg SHALL hold FRAC, pixel/velocity widths, SCREEN_W/H defaults, and the slot-state struct type.
REQ-030 Sub-module bullet_slot SHALL implement one slot (load, integrate, gravity, bounds check), instantiated N_SLOTS times; priority encoder, drop counter, and read mux stay in bullet_pool.

Verification
REQ-031 rst, fire x=100,y=50,vx=16,vy=-32 -> slot0 active; after 3 more edges rd_x=103, rd_y=44.
REQ-032 GRAV_16X=8, fire y=0 vy=0 x=10 vx=0 -> vy 0,8,16,...; py_16x 0,0,8,24,48 on successive edges after launch; y pixel 0,0,0,1,3.
REQ-033 Fill 8 slots, 9th fire -> fire_ack=0, drop_cnt=1, active_mask=0xFF; 300 overflow fires -> drop_cnt=255.
REQ-034 Slot 2 at x=639 vx=16 exits on same edge as fire with slots 0..7 otherwise full -> fire dropped; fire next edge -> lands in slot 2.
REQ-035 Fire x=700 -> slot active one cycle then cleared; rd_idx=7 (empty) -> rd_active=0, rd_x=0.
REQ-036 rst pulse with 5 bullets in flight -> active_mask=0 immediately; next fire uses slot 0.
